// File: rtl/imem_loader_pkg.sv
// Shared types and default sizes for the instruction-memory boot/run sequencer.
package loader_pkg;
  localparam int D_DEF = 12;
  localparam int W_DEF = 9;
  localparam int C_DEF = 16;

  // PC value at which the core signals completion; never a program slot.
  localparam logic [D_DEF-1:0] DONE_ADDR = '1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
endpackage

// File: rtl/imem_loader_if.sv
// Word stream into the loader plus the instruction-memory write port it drives.
interface imem_loader_if #(
  parameter int D = loader_pkg::D_DEF,
  parameter int W = loader_pkg::W_DEF
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         in_ready;
  logic         imem_we;
  logic [D-1:0] imem_addr;
  logic [W-1:0] imem_wdata;

  modport master (output in_valid, in_data, in_last,
                  input  in_ready, imem_we, imem_addr, imem_wdata);
  modport slave  (input  in_valid, in_data, in_last,
                  output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader_sat_counter.sv
// Up-counter with synchronous clear that sticks at its maximum value.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset || clr)       q <= '0;
    else if (en && q != '1) q <= q + WIDTH'(1);
  end
endmodule

// File: rtl/imem_loader.sv
// Boot/run sequencer: loads program words from address 0, releases the core, times it to done.
// Optional XOR checksum of loaded words under `LOADER_CKSUM_EN (cksum reads 0 otherwise).
module imem_loader
  import loader_pkg::*;
#(
  parameter int D = D_DEF,
  parameter int W = W_DEF,
  parameter int C = C_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_start,
  imem_loader_if.slave bus,
  output logic         core_reset,
  input  logic         core_done,
  output logic [D-1:0] prog_len,
  output logic [C-1:0] run_cycles,
  output logic         finished,
  output logic         error,
  output logic [W-1:0] cksum
);
  localparam logic [D-1:0] SENTINEL = '1;
  localparam logic [D-1:0] LAST_WR  = SENTINEL - D'(1);

  state_t       state, state_nx;
  logic [D-1:0] wr_ptr;
  logic         xfer, start_ok, cnt_en;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.imem_we   = 1'b0;
    core_reset    = 1'b1;
    finished      = 1'b0;
    start_ok      = 1'b0;
    cnt_en        = 1'b0;
    xfer          = 1'b0;
    case (state)
      IDLE: if (load_start) begin
        start_ok = 1'b1;
        state_nx = LOAD;
      end
      LOAD: begin
        bus.in_ready = 1'b1;
        xfer         = bus.in_valid;
        bus.imem_we  = xfer;
        if (xfer) begin
          if (bus.in_last)            state_nx = RUN;
          else if (wr_ptr == LAST_WR) state_nx = IDLE;  // next slot is the done sentinel
        end
      end
      RUN: begin
        core_reset = 1'b0;
        if (core_done) state_nx = DONE;
        else           cnt_en   = 1'b1;
      end
      DONE: begin
        finished = 1'b1;
        if (load_start) begin
          start_ok = 1'b1;
          state_nx = LOAD;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.imem_addr  = wr_ptr;
  assign bus.imem_wdata = bus.in_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      prog_len <= '0;
      error    <= 1'b0;
    end else if (start_ok) begin
      wr_ptr <= '0;
      error  <= 1'b0;
    end else if (xfer) begin
      wr_ptr <= wr_ptr + D'(1);
      if (bus.in_last)            prog_len <= wr_ptr + D'(1);
      else if (wr_ptr == LAST_WR) error    <= 1'b1;
    end
  end

`ifdef LOADER_CKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || start_ok) cksum <= '0;
    else if (xfer)         cksum <= cksum ^ bus.in_data;
  end
`else
  assign cksum = '0;
`endif

  sat_counter #(.WIDTH(C)) u_run_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok),
    .en    (cnt_en),
    .q     (run_cycles)
  );
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader built with D=4, C=4 so overflow and saturation are reachable.
module tb_imem_loader;
  localparam int D = 4;
  localparam int W = 9;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         reset, load_start, core_done;
  logic         core_reset, finished, error;
  logic [D-1:0] prog_len;
  logic [C-1:0] run_cycles;
  logic [W-1:0] cksum;
  int           n_chk = 0;
  int           n_err = 0;

  imem_loader_if #(.D(D), .W(W)) bus ();

  imem_loader #(.D(D), .W(W), .C(C)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .bus        (bus),
    .core_reset (core_reset),
    .core_done  (core_done),
    .prog_len   (prog_len),
    .run_cycles (run_cycles),
    .finished   (finished),
    .error      (error),
    .cksum      (cksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] ck(input logic [W-1:0] v);
`ifdef LOADER_CKSUM_EN
    return v;
`else
    return (v & '0);
`endif
  endfunction

  logic        pat_v [7] = '{0, 1, 0, 1, 0, 0, 1};
  logic [8:0]  pat_d [3] = '{9'h001, 9'h0AB, 9'h1FF};

  initial begin
    int k;
    reset = 1'b1; load_start = 1'b0; core_done = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    tick(); tick();
    check("rst_core_reset", core_reset, 1);
    check("rst_in_ready",   bus.in_ready, 0);
    check("rst_imem_we",    bus.imem_we, 0);
    check("rst_imem_addr",  bus.imem_addr, 0);
    check("rst_prog_len",   prog_len, 0);
    check("rst_run_cycles", run_cycles, 0);
    check("rst_finished",   finished, 0);
    check("rst_error",      error, 0);
    check("rst_cksum",      cksum, 0);

    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'(($urandom) & 1);
      bus.in_data  = W'($urandom);
      #1;
      check("idle_no_we", bus.imem_we, 0);
      check("idle_core_reset", core_reset, 1);
      tick();
    end

    // three-word load with valid gaps
    bus.in_valid = 1'b0;
    load_start = 1'b1; tick(); load_start = 1'b0;
    k = 0;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = pat_v[i];
      bus.in_data  = pat_v[i] ? pat_d[k] : 9'h155;
      bus.in_last  = pat_v[i] && (k == 2);
      #1;
      check("load_ready", bus.in_ready, 1);
      check("load_we", bus.imem_we, 32'(pat_v[i]));
      check("load_core_reset", core_reset, 1);
      if (pat_v[i]) begin
        check("load_addr", bus.imem_addr, k);
        check("load_wdata", bus.imem_wdata, pat_d[k]);
        k++;
      end
      tick();
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    check("run_released", core_reset, 0);
    check("run_prog_len", prog_len, 3);
    check("run_cksum", cksum, ck(9'h155));
    check("run_in_ready", bus.in_ready, 0);
    load_start = 1'b1;  // ignored in RUN
    tick();
    load_start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    check("run_cnt_10", run_cycles, 10);
    core_done = 1'b1; tick(); core_done = 1'b0;
    check("done_cycles", run_cycles, 10);
    check("done_finished", finished, 1);
    check("done_core_reset", core_reset, 1);
    check("done_prog_len", prog_len, 3);
    core_done = 1'b1; tick(); core_done = 1'b0;
    check("done_hold_cycles", run_cycles, 10);

    // saturation: single-word program, core runs 20 cycles
    load_start = 1'b1; tick(); load_start = 1'b0;
    check("reload_cycles_clr", run_cycles, 0);
    check("reload_finished", finished, 0);
    check("reload_cksum_clr", cksum, 0);
    bus.in_valid = 1'b1; bus.in_data = 9'h123; bus.in_last = 1'b1;
    #1;
    check("sat_addr", bus.imem_addr, 0);
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    check("sat_prog_len", prog_len, 1);
    check("sat_cksum", cksum, ck(9'h123));
    for (int i = 0; i < 20; i++) tick();
    check("sat_cnt", run_cycles, 15);
    core_done = 1'b1; tick(); core_done = 1'b0;
    check("sat_finished", finished, 1);
    check("sat_final", run_cycles, 15);

    // overflow: 15 words without last on a 16-entry space
    reset = 1'b1; tick(); reset = 1'b0;
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      bus.in_valid = 1'b1; bus.in_data = W'(i); bus.in_last = 1'b0;
      #1;
      check("ovf_we", bus.imem_we, 1);
      check("ovf_addr", bus.imem_addr, i);
      tick();
    end
    check("ovf_error", error, 1);
    check("ovf_idle_ready", bus.in_ready, 0);
    check("ovf_core_reset", core_reset, 1);
    check("ovf_prog_len", prog_len, 0);
    check("ovf_finished", finished, 0);
    check("ovf_cksum", cksum, ck(9'h00F));
    check("ovf_no_we", bus.imem_we, 0);
    tick();
    check("ovf_error_sticky", error, 1);
    bus.in_valid = 1'b0;
    load_start = 1'b1; tick(); load_start = 1'b0;
    check("ovf_error_clr", error, 0);

    // load_start with a transfer is ignored; reset aborts mid-load
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = W'(9'h040 + i); bus.in_last = 1'b0;
      load_start = (i == 1);
      #1;
      check("mid_addr", bus.imem_addr, i);
      tick();
    end
    load_start = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    #1;
    check("abort_no_we", bus.imem_we, 0);
    check("abort_ready", bus.in_ready, 0);
    check("abort_addr", bus.imem_addr, 0);
    bus.in_valid = 1'b0;
    load_start = 1'b1; tick(); load_start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 9'h0AA; bus.in_last = 1'b1;
    #1;
    check("restart_we", bus.imem_we, 1);
    check("restart_addr", bus.imem_addr, 0);
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    check("restart_run", core_reset, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
